// File: rtl/uart_pkg.sv
// Shared types and constants for the UART result framer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam int         FRAME_LEN      = 4;
    localparam logic [7:0] HEADER_DEFAULT = 8'hAA;
    localparam logic [3:0] DIGIT_INVALID  = 4'hF;

    // One buffered recognition result; 12 bits wide when packed.
    typedef struct packed {
        logic [3:0] digit;
        logic [7:0] score;
    } result_t;

    localparam int ENTRY_W = $bits(result_t);

    // Digits outside 0..9 are replaced by a marker the receiver can spot.
    function automatic logic [3:0] sanitize_digit(input logic [3:0] d);
        return (d > 4'd9) ? DIGIT_INVALID : d;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding recognition results between classifier and framer.
// Latency: written entry visible at pop_dat the cycle after push.
// Backpressure: push ignored while full, pop ignored while empty; no push-through when full.
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   push_vld, push_dat : write request and data
//   pop_rdy            : consume head entry
//   pop_dat            : head entry (valid while !empty)
//   full, empty, level : occupancy status, level counts 0..DEPTH
module result_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_rdy && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so pointers wrap by plain overflow.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: nothing is read until level says it was written.
    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_result_framer.sv
// Buffers digit/score results and sends each as a 4-byte frame {HDR, digit, score, xor} to a UART.
// Latency: push into empty idle framer -> uart_en high 3 cycles later; next frame popped the cycle after the last byte.
// Backpressure: res_ready = !fifo_full; per byte waits for uart_tx_busy rise/fall, aborts frame after BUSY_TIMEOUT.
//
// Ports:
//   sys_clk, sys_rst_n               : clock, asynchronous active-low reset
//   res_valid/res_ready/res_digit/res_score : result input handshake
//   uart_en, uart_din, uart_tx_busy  : byte request interface to transmitter
//   frame_active, drop_err, fifo_level : status
module uart_result_framer
    import uart_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] HEADER       = HEADER_DEFAULT,
    parameter int         BUSY_TIMEOUT = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [3:0]                    res_digit,
    input  logic [7:0]                    res_score,
    output logic                          uart_en,
    output logic [7:0]                    uart_din,
    input  logic                          uart_tx_busy,
    output logic                          frame_active,
    output logic                          drop_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TMO_W = $clog2(BUSY_TIMEOUT) + 1;

    // FIFO interface
    result_t push_entry;
    result_t fifo_head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_pop;
    logic    fifo_push;

    // FSM and frame state
    state_t     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic [7:0] score_q, score_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic       uart_en_q, uart_en_d;
    logic [7:0] uart_din_q, uart_din_d;
    logic       frame_active_q, frame_active_d;
    logic       drop_err_q, drop_err_d;

    logic [7:0] checksum;
    logic [7:0] cur_byte;

    assign push_entry.digit = sanitize_digit(res_digit);
    assign push_entry.score = res_score;
    assign fifo_push        = res_valid && res_ready;
    assign res_ready        = !fifo_full;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push_vld  (fifo_push),
        .push_dat  (push_entry),
        .pop_rdy   (fifo_pop),
        .pop_dat   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign checksum = HEADER ^ {4'h0, digit_q} ^ score_q;

    always_comb begin
        cur_byte = checksum;
        case (byte_idx_q)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = {4'h0, digit_q};
            2'd2:    cur_byte = score_q;
            default: cur_byte = checksum;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        digit_d        = digit_q;
        score_d        = score_q;
        byte_idx_d     = byte_idx_q;
        tmo_cnt_d      = tmo_cnt_q;
        uart_en_d      = uart_en_q;
        uart_din_d     = uart_din_q;
        frame_active_d = frame_active_q;
        drop_err_d     = 1'b0;
        fifo_pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    digit_d    = fifo_head.digit;
                    score_d    = fifo_head.score;
                    byte_idx_d = 2'd0;
                    state_d    = LOAD;
                end
            end

            LOAD: begin
                uart_din_d     = cur_byte;
                uart_en_d      = 1'b1;
                frame_active_d = 1'b1;
                tmo_cnt_d      = '0;
                state_d        = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                // Busy wins over timeout: a busy seen on the last allowed cycle still counts.
                if (uart_tx_busy) begin
                    uart_en_d = 1'b0;
                    state_d   = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
                    uart_en_d      = 1'b0;
                    drop_err_d     = 1'b1;
                    frame_active_d = 1'b0;
                    state_d        = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (byte_idx_q == 2'(FRAME_LEN - 1)) begin
                        frame_active_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = LOAD;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            digit_q        <= '0;
            score_q        <= '0;
            byte_idx_q     <= '0;
            tmo_cnt_q      <= '0;
            uart_en_q      <= 1'b0;
            uart_din_q     <= '0;
            frame_active_q <= 1'b0;
            drop_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            digit_q        <= digit_d;
            score_q        <= score_d;
            byte_idx_q     <= byte_idx_d;
            tmo_cnt_q      <= tmo_cnt_d;
            uart_en_q      <= uart_en_d;
            uart_din_q     <= uart_din_d;
            frame_active_q <= frame_active_d;
            drop_err_q     <= drop_err_d;
        end
    end

    assign uart_en      = uart_en_q;
    assign uart_din     = uart_din_q;
    assign frame_active = frame_active_q;
    assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_uart_result_framer.sv
// Directed bench for uart_result_framer with a behavioural UART transmitter model.
// Latency: model raises busy 3 cycles after uart_en rise, latches uart_din 2 cycles after it.
// Backpressure: model busy lasts BPS_CNT*10 cycles; model can be muted to force timeouts.
module tb_uart_result_framer;

    localparam int BPS_CNT  = 2;
    localparam int BUSY_LEN = BPS_CNT * 10;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_digit;
    logic [7:0] res_score;
    logic       uart_en;
    logic [7:0] uart_din;
    logic       uart_tx_busy;
    logic       frame_active;
    logic       drop_err;
    logic [2:0] fifo_level;

    always #5 sys_clk = ~sys_clk;

    uart_result_framer #(
        .FIFO_DEPTH   (4),
        .HEADER       (8'hAA),
        .BUSY_TIMEOUT (16)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_digit    (res_digit),
        .res_score    (res_score),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .uart_tx_busy (uart_tx_busy),
        .frame_active (frame_active),
        .drop_err     (drop_err),
        .fifo_level   (fifo_level)
    );

    // ---------------- transmitter model ----------------
    logic       model_en;
    logic       en_prev;
    logic [2:0] rise_pipe;
    logic       rise;
    int         busy_cnt;
    logic [7:0] sent_mem [256];
    int         sent_cnt = 0;

    assign rise = uart_en && !en_prev;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            en_prev      <= 1'b0;
            rise_pipe    <= '0;
            uart_tx_busy <= 1'b0;
            busy_cnt     <= 0;
        end else begin
            en_prev   <= uart_en;
            rise_pipe <= {rise_pipe[1:0], rise};
            if (rise_pipe[1] && model_en) begin
                sent_mem[sent_cnt[7:0]] <= uart_din;
                sent_cnt <= sent_cnt + 1;
            end
            if (rise_pipe[2] && model_en) begin
                uart_tx_busy <= 1'b1;
                busy_cnt     <= BUSY_LEN;
            end else if (busy_cnt > 1) begin
                busy_cnt <= busy_cnt - 1;
            end else if (busy_cnt == 1) begin
                busy_cnt     <= 0;
                uart_tx_busy <= 1'b0;
            end
        end
    end

    // ---------------- bench helpers ----------------
    int checks   = 0;
    int failures = 0;
    int rd_idx   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [31:0] exp_frame(input logic [3:0] d, input logic [7:0] s);
        logic [7:0] b1;
        b1 = {4'h0, (d > 4'd9) ? 4'hF : d};
        return {8'hAA, b1, s, 8'hAA ^ b1 ^ s};
    endfunction

    task automatic push1(input logic [3:0] d, input logic [7:0] s);
        res_valid = 1'b1;
        res_digit = d;
        res_score = s;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while ((sent_cnt - rd_idx) < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(sent_cnt - rd_idx), 32'(n));
    endtask

    task automatic wait_fa(input logic lvl, input int budget, input string tag);
        int k = 0;
        while (frame_active !== lvl && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(frame_active), 32'(lvl));
    endtask

    task automatic get_frame(output logic [31:0] f);
        if ((sent_cnt - rd_idx) >= 4) begin
            f = {sent_mem[rd_idx[7:0]], sent_mem[8'(rd_idx + 1)],
                 sent_mem[8'(rd_idx + 2)], sent_mem[8'(rd_idx + 3)]};
            rd_idx += 4;
        end else begin
            f = 'x;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] fr;
        logic [3:0]  pd [5];
        logic [7:0]  ps [5];
        int          n;
        int          en_seen;

        pd = '{4'd9, 4'd0, 4'd10, 4'd2, 4'd6};
        ps = '{8'h00, 8'hFF, 8'h5A, 8'h33, 8'h66};

        sys_rst_n = 1'b0;
        res_valid = 1'b0;
        res_digit = '0;
        res_score = '0;
        model_en  = 1'b1;
        repeat (3) tick();

        chk("rst_ready", 32'(res_ready), 32'(1));
        chk("rst_en", 32'(uart_en), 32'(0));
        chk("rst_din", 32'(uart_din), 32'(0));
        chk("rst_fa", 32'(frame_active), 32'(0));
        chk("rst_drop", 32'(drop_err), 32'(0));
        chk("rst_level", 32'(fifo_level), 32'(0));
        sys_rst_n = 1'b1;
        tick();

        // 1: digit 7, score C8 -> AA 07 C8 65, 3-cycle latency
        push1(4'd7, 8'hC8);
        chk("t1_lvl_after_push", 32'(fifo_level), 32'(1));
        chk("t1_en_c1", 32'(uart_en), 32'(0));
        tick();
        chk("t1_en_c2", 32'(uart_en), 32'(0));
        chk("t1_lvl_after_pop", 32'(fifo_level), 32'(0));
        tick();
        chk("t1_en_c3", 32'(uart_en), 32'(1));
        chk("t1_din_hdr", 32'(uart_din), 32'(8'hAA));
        chk("t1_fa_up", 32'(frame_active), 32'(1));
        wait_bytes(4, 400, "t1_bytes");
        chk("t1_fa_mid", 32'(frame_active), 32'(1));
        wait_fa(1'b0, 100, "t1_fa_down");
        chk("t1_busy_at_end", 32'(uart_tx_busy), 32'(0));
        get_frame(fr);
        chk("t1_frame", fr, 32'hAA07C865);

        // 2: invalid digit 12 -> 0F
        push1(4'd12, 8'h10);
        wait_bytes(4, 400, "t2_bytes");
        wait_fa(1'b0, 100, "t2_fa_down");
        get_frame(fr);
        chk("t2_frame", fr, 32'hAA0F10B5);

        // 3: five pushes while a frame is in flight
        push1(4'd1, 8'h11);
        n = 0;
        while (!uart_en && n < 20) begin
            tick();
            n++;
        end
        chk("t3_start", 32'(uart_en), 32'(1));
        for (int i = 0; i < 5; i++) begin
            res_valid = 1'b1;
            res_digit = pd[i];
            res_score = ps[i];
            chk("t3_ready", 32'(res_ready), 32'(i < 4));
            if (i == 4) chk("t3_level_full", 32'(fifo_level), 32'(4));
            tick();
        end
        res_valid = 1'b0;
        wait_bytes(20, 1500, "t3_bytes");
        get_frame(fr);
        chk("t3_frame0", fr, exp_frame(4'd1, 8'h11));
        for (int f = 0; f < 4; f++) begin
            get_frame(fr);
            chk("t3_frame", fr, exp_frame(pd[f], ps[f]));
        end
        wait_fa(1'b0, 100, "t3_fa_down");
        chk("t3_level_empty", 32'(fifo_level), 32'(0));

        // 4: transmitter silent -> timeout after 16 cycles, next entry sent
        model_en = 1'b0;
        push1(4'd3, 8'h20);
        push1(4'd4, 8'h40);
        n = 0;
        while (!uart_en && n < 20) begin
            tick();
            n++;
        end
        chk("t4_start", 32'(uart_en), 32'(1));
        n = 0;
        en_seen = 0;
        while (uart_en && n < 100) begin
            if (drop_err) en_seen++;
            n++;
            tick();
        end
        chk("t4_en_width", 32'(n), 32'(16));
        chk("t4_no_early_drop", 32'(en_seen), 32'(0));
        chk("t4_drop_pulse", 32'(drop_err), 32'(1));
        chk("t4_fa_abort", 32'(frame_active), 32'(0));
        model_en = 1'b1;
        tick();
        chk("t4_drop_one_cycle", 32'(drop_err), 32'(0));
        wait_bytes(4, 400, "t4_bytes");
        wait_fa(1'b0, 100, "t4_fa_down");
        get_frame(fr);
        chk("t4_frame", fr, 32'hAA0440EE);

        // 5: reset during third byte with 3 entries queued
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1;
            res_digit = 4'(5 + i);
            res_score = 8'(8'h50 + 8'h10 * i);
            tick();
        end
        res_valid = 1'b0;
        chk("t5_level_queued", 32'(fifo_level), 32'(3));
        wait_bytes(3, 300, "t5_bytes");
        sys_rst_n = 1'b0;
        #1;
        chk("t5_en", 32'(uart_en), 32'(0));
        chk("t5_din", 32'(uart_din), 32'(0));
        chk("t5_level", 32'(fifo_level), 32'(0));
        chk("t5_ready", 32'(res_ready), 32'(1));
        chk("t5_fa", 32'(frame_active), 32'(0));
        chk("t5_drop", 32'(drop_err), 32'(0));
        tick();
        tick();
        sys_rst_n = 1'b1;
        rd_idx = sent_cnt;
        en_seen = 0;
        repeat (200) begin
            tick();
            if (uart_en) en_seen++;
        end
        chk("t5_quiet_en", 32'(en_seen), 32'(0));
        chk("t5_quiet_bytes", 32'(sent_cnt - rd_idx), 32'(0));

        // 6: push+pop at level 2, then 10 frames through wrapping pointers
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1;
            res_digit = 4'(i);
            res_score = {4'(i), ~4'(i)};
            tick();
        end
        res_valid = 1'b0;
        wait_fa(1'b1, 20, "t6_fa_up");
        wait_fa(1'b0, 400, "t6_fa_down");
        chk("t6_level_before", 32'(fifo_level), 32'(2));
        res_valid = 1'b1;
        res_digit = 4'd3;
        res_score = {4'd3, ~4'd3};
        tick();
        res_valid = 1'b0;
        chk("t6_level_same", 32'(fifo_level), 32'(2));
        for (int i = 4; i < 10; i++) begin
            res_valid = 1'b1;
            res_digit = 4'(i);
            res_score = {4'(i), ~4'(i)};
            n = 0;
            while (!res_ready && n < 1000) begin
                tick();
                n++;
            end
            tick();
        end
        res_valid = 1'b0;
        wait_bytes(40, 3000, "t6_bytes");
        for (int i = 0; i < 10; i++) begin
            get_frame(fr);
            chk("t6_frame", fr, exp_frame(4'(i), {4'(i), ~4'(i)}));
        end
        wait_fa(1'b0, 100, "t6_fa_down_end");
        chk("t6_level_empty", 32'(fifo_level), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
